// File: rtl/param_cam_pkg.sv
// Shared constants and helpers for the parametrised CAM: default geometry,
// address-width derivation and the popcount behind hit_cnt.
package param_cam_pkg;

   localparam int CAM_DEPTH_DEF = 16;
   localparam int CAM_WIDTH_DEF = 8;
   localparam int CAM_DEPTH_MAX = 256;

   function automatic int cam_aw(input int depth);
      int aw;
      aw = 0;
      while ((1 << aw) < depth) aw++;
      return aw;
   endfunction

   // Sized for the largest supported DEPTH; callers zero-extend their match vector.
   function automatic logic [8:0] cam_popcount(input logic [CAM_DEPTH_MAX-1:0] vec);
      logic [8:0] cnt;
      cnt = '0;
      for (int i = 0; i < CAM_DEPTH_MAX; i++) cnt = cnt + 9'(vec[i]);
      return cnt;
   endfunction

endpackage

// File: rtl/param_cam_if.sv
// Request/response bundle between a lookup source and param_cam.
interface param_cam_if
   import param_cam_pkg::*;
#(
   parameter int DEPTH = CAM_DEPTH_DEF,
   parameter int WIDTH = CAM_WIDTH_DEF
);
   localparam int AW = cam_aw(DEPTH);

   logic             wen;
   logic             inv;
   logic             ren;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] mask;
   logic [AW-1:0]    addr;
   logic [AW-1:0]    dout;
   logic             hit;
   logic [AW:0]      hit_cnt;

   modport master (
      output wen, inv, ren, din, mask, addr,
      input  dout, hit, hit_cnt
   );

   modport slave (
      input  wen, inv, ren, din, mask, addr,
      output dout, hit, hit_cnt
   );
endinterface

// File: rtl/param_cam_prio_enc.sv
// Combinational reduction of the CAM match vector: highest set index,
// any-set flag and number of set bits.
module cam_prio_enc
   import param_cam_pkg::*;
#(
   parameter int DEPTH = CAM_DEPTH_DEF,
   localparam int AW = cam_aw(DEPTH)
) (
   input  logic [DEPTH-1:0] match,
   output logic [AW-1:0]    idx,
   output logic             any,
   output logic [AW:0]      cnt
);

   // Ascending scan: the last assignment is the highest matching index.
   always_comb begin
      idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (match[i]) idx = AW'(i);
      end
   end

   assign any = |match;
   assign cnt = (AW+1)'(cam_popcount(CAM_DEPTH_MAX'(match)));

endmodule

// File: rtl/param_cam.sv
// Parametrised CAM with per-entry valid bits, registered search results.
// Define PARAM_CAM_MASK_EN to make the mask input a per-bit ternary care-mask.
module param_cam
   import param_cam_pkg::*;
#(
   parameter int DEPTH = CAM_DEPTH_DEF,
   parameter int WIDTH = CAM_WIDTH_DEF,
   localparam int AW = cam_aw(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   param_cam_if.slave  bus
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] match;
   logic [WIDTH-1:0] eff_mask;
   logic [AW-1:0]    enc_idx;
   logic             enc_any;
   logic [AW:0]      enc_cnt;

`ifdef PARAM_CAM_MASK_EN
   assign eff_mask = bus.mask;
`else
   assign eff_mask = '1;
`endif

   // Data array carries no reset; valid bits alone decide what is visible.
   always_ff @(posedge clk) begin
      if (bus.wen) mem[bus.addr] <= bus.din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (bus.wen) begin
         valid[bus.addr] <= 1'b1;
      end else if (bus.inv) begin
         valid[bus.addr] <= 1'b0;
      end
   end

   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = valid[i] && (((mem[i] ^ bus.din) & eff_mask) == '0);
      end
   end

   cam_prio_enc #(.DEPTH(DEPTH)) u_enc (
      .match (match),
      .idx   (enc_idx),
      .any   (enc_any),
      .cnt   (enc_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.dout    <= '0;
         bus.hit     <= 1'b0;
         bus.hit_cnt <= '0;
      end else if (bus.ren) begin
         bus.dout    <= enc_idx;
         bus.hit     <= enc_any;
         bus.hit_cnt <= enc_cnt;
      end else begin
         bus.dout    <= '0;
         bus.hit     <= 1'b0;
         bus.hit_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_param_cam.sv
// Directed and randomised checks of param_cam against an array-based model.
module tb_param_cam;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   param_cam_if #(.DEPTH(16), .WIDTH(8)) bus ();

   param_cam #(.DEPTH(16), .WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] m_data  [16];
   bit         m_valid [16];
   int         e_dout;
   int         e_hit;
   int         e_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "_dout"}, 32'(bus.dout), 32'(e_dout));
      check({tag, "_hit"},  32'(bus.hit),  32'(e_hit));
      check({tag, "_cnt"},  32'(bus.hit_cnt), 32'(e_cnt));
   endtask

   task automatic model_reset();
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
      e_dout = 0;
      e_hit  = 0;
      e_cnt  = 0;
   endtask

   // One clock: search sees the table as it was before the edge, then writes apply.
   task automatic cyc(input string tag, input bit w, input bit i, input bit r,
                      input logic [7:0] d, input logic [7:0] m, input logic [3:0] a);
      logic [7:0] em;
      bus.wen  = w;
      bus.inv  = i;
      bus.ren  = r;
      bus.din  = d;
      bus.mask = m;
      bus.addr = a;
      @(posedge clk);
`ifdef PARAM_CAM_MASK_EN
      em = m;
`else
      em = 8'hFF;
`endif
      e_dout = 0;
      e_hit  = 0;
      e_cnt  = 0;
      if (r) begin
         for (int k = 0; k < 16; k++) begin
            if (m_valid[k] && (((m_data[k] ^ d) & em) == 8'h00)) begin
               e_cnt++;
               e_dout = k;
            end
         end
         e_hit = (e_cnt > 0) ? 1 : 0;
      end
      if (w) begin
         m_data[a]  = d;
         m_valid[a] = 1'b1;
      end else if (i) begin
         m_valid[a] = 1'b0;
      end
      #1;
      check_outputs(tag);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      bus.wen  = 1'b0;
      bus.inv  = 1'b0;
      bus.ren  = 1'b0;
      bus.din  = '0;
      bus.mask = '0;
      bus.addr = '0;
      model_reset();
      #12;
      check_outputs("reset");
      rst_n = 1'b1;

      cyc("wr7", 1, 0, 0, 8'd8, 8'hFF, 4'd7);
      cyc("wr9", 1, 0, 0, 8'd8, 8'hFF, 4'd9);
      cyc("srch8", 0, 0, 1, 8'd8, 8'hFF, 4'd0);
      check("tp_dout9", 32'(bus.dout), 32'd9);
      check("tp_cnt2", 32'(bus.hit_cnt), 32'd2);

      cyc("inv9", 0, 1, 0, 8'd0, 8'hFF, 4'd9);
      cyc("srch8b", 0, 0, 1, 8'd8, 8'hFF, 4'd0);
      check("tp_dout7", 32'(bus.dout), 32'd7);
      cyc("srch35", 0, 0, 1, 8'd35, 8'hFF, 4'd0);
      check("tp_miss", 32'(bus.hit), 32'd0);

      for (int k = 0; k < 16; k++) cyc("fill", 1, 0, 0, 8'(k * 3), 8'hFF, 4'(k));
      cyc("srch45", 0, 0, 1, 8'd45, 8'hFF, 4'd0);
      check("tp_dout15", 32'(bus.dout), 32'd15);
      cyc("srch0", 0, 0, 1, 8'd0, 8'hFF, 4'd0);
      check("tp_zero_hit", 32'(bus.hit), 32'd1);
      cyc("idle", 0, 0, 0, 8'd0, 8'hFF, 4'd0);

      cyc("inv11", 0, 1, 0, 8'd0, 8'hFF, 4'd11);
      cyc("rbw", 1, 0, 1, 8'd33, 8'hFF, 4'd4);
      check("tp_rbw_miss", 32'(bus.hit), 32'd0);
      cyc("rbw_again", 0, 0, 1, 8'd33, 8'hFF, 4'd0);
      check("tp_rbw_dout4", 32'(bus.dout), 32'd4);
      cyc("wen_inv", 1, 1, 0, 8'd33, 8'hFF, 4'd4);
      cyc("wen_inv_srch", 0, 0, 1, 8'd33, 8'hFF, 4'd0);
      check("tp_wen_wins", 32'(bus.hit), 32'd1);

      cyc("wr8", 1, 0, 0, 8'd8, 8'hFF, 4'd7);
      cyc("pre_rst", 0, 0, 1, 8'd8, 8'hFF, 4'd0);
      check("tp_pre_rst_hit", 32'(bus.hit), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      #2;
      rst_n = 1'b1;
      cyc("post_rst", 0, 0, 1, 8'd8, 8'hFF, 4'd0);
      check("tp_post_rst_miss", 32'(bus.hit), 32'd0);

      cyc("m_wr2", 1, 0, 0, 8'h21, 8'hFF, 4'd2);
      cyc("m_wr5", 1, 0, 0, 8'h31, 8'hFF, 4'd5);
      cyc("m_srch", 0, 0, 1, 8'h01, 8'h0F, 4'd0);
`ifdef PARAM_CAM_MASK_EN
      check("tp_mask_dout5", 32'(bus.dout), 32'd5);
      check("tp_mask_cnt2", 32'(bus.hit_cnt), 32'd2);
`else
      check("tp_nomask_miss", 32'(bus.hit), 32'd0);
`endif

      for (int n = 0; n < 400; n++) begin
         cyc("rand",
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) != 0),
             8'($urandom_range(0, 15)),
             8'($urandom),
             4'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/param_cam.md
# param_cam

Parametrised content-addressable memory: DEPTH entries of WIDTH-bit data, each with a valid bit, written by address and searched by content. A search returns the highest matching index, a hit flag and the number of matching entries, all registered one cycle after the request. It is the generalised successor to the team's fixed 16x8 CAM: adds per-entry valid bits, explicit invalidation, a hit count and an optional ternary search mask. It sits as a lookup table between a request source and a consumer that needs an index for a key.

## Interface
- `DEPTH`, 16: number of entries, power of two, 2..256.
- `WIDTH`, 8: data/key width, 1..64.
- `AW`, $clog2(DEPTH): address width (derived, not overridden).
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wen`  in  1  write `din` into entry `addr` and set its valid bit.
- `inv`  in  1  clear the valid bit of entry `addr`.
- `ren`  in  1  search request with key `din`.
- `din`  in  WIDTH  write data / search key.
- `mask`  in  WIDTH  search care-mask, 1 = compare bit (see Configuration).
- `addr`  in  AW  write/invalidate address.
- `dout`  out  AW  highest matching index.
- `hit`  out  1  at least one valid entry matched.
- `hit_cnt`  out  AW+1  number of valid matching entries, 0..DEPTH.

## Operation
- Reset (async assert, sync release): all valid bits 0; `dout`=0, `hit`=0, `hit_cnt`=0. Data array is not cleared; valid bits make its contents irrelevant.
- Write (`wen`=1): `mem[addr]`<=`din`, `valid[addr]`<=1. Rewriting an entry overwrites it; duplicates across entries are allowed.
- Invalidate (`inv`=1, `wen`=0): `valid[addr]`<=0. With `wen`=1 and `inv`=1 together, the write wins and the entry ends valid.
- Search (`ren`=1): entry i matches iff `valid[i]` and `((mem[i] ^ din) & effective_mask) == 0`. `hit`=OR of matches. `dout`=highest matching index, or 0 if none. `hit_cnt`=popcount of the matches.
- No search (`ren`=0): next edge loads `dout`=0, `hit`=0, `hit_cnt`=0.
- Simultaneous `ren` and `wen`/`inv`: search uses the array state from before the edge (read-before-write). `din` serves as both write data and key in that cycle.
- Entries are never allocated automatically. The caller owns addressing.

## Timing
- Write/invalidate: effective at the rising edge where sampled; visible to a search issued the following cycle.
- Search latency: 1 cycle. Request sampled at edge N; `dout`/`hit`/`hit_cnt` valid after edge N and held until edge N+1.
- Throughput: one search per cycle, back-to-back, with no stalls.
- Outputs are purely registered; no combinational path from inputs to outputs.
- Reset asserted mid-operation clears outputs and valid bits immediately. A search in flight is discarded.

## Configuration
- `PARAM_CAM_MASK_EN` defined: `mask` gates the compare per bit (ternary search), so `mask`=0 matches every valid entry.
- Not defined: `mask` port present but ignored; effective_mask is all ones (exact-match search).

## Structure
- Shared package `param_cam_pkg`: default `DEPTH`/`WIDTH` constants, an address-width function (clog2), and a popcount function used for `hit_cnt`.
- One sub-module `cam_prio_enc`: combinational, DEPTH-bit match vector in; highest set index, any-set flag and popcount out. The top registers its outputs.
- Top holds the data array, valid vector, match generation and output registers.

## Test plan
- Reset, then write 8 to addr 7 and 8 to addr 9, then search 8 -> next cycle `dout`=9, `hit`=1, `hit_cnt`=2.
- Invalidate addr 9, search 8 -> `dout`=7, `hit`=1, `hit_cnt`=1. Search 35 -> `dout`=0, `hit`=0, `hit_cnt`=0.
- Fill all 16 entries with data i*3, search 45 -> `dout`=15, `hit`=1. Search 0 -> `dout`=0, `hit`=1, `hit_cnt`=1. Deassert `ren` -> all outputs 0.
- Same cycle: `wen`=1, addr 4, `din`=33, `ren`=1, where 33 is not yet stored -> `hit`=0. Repeat the search next cycle -> `dout`=4, `hit`=1. `wen`+`inv` together on addr 4 -> entry stays valid.
- With `PARAM_CAM_MASK_EN`: entries 2=0x21, 5=0x31; key 0x01 with `mask`=0x0F -> `dout`=5, `hit_cnt`=2. Without the macro, the same stimulus gives `hit`=0.
- Assert `rst_n` low while a search is pending -> outputs 0 immediately. After release, search 8 -> `hit`=0 (valid bits cleared).
